// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer
// Purpose  : Frame-level controller that runs the CNN layer blocks (conv,
//            relu, maxpool, dense, argmax) one after another via start/done
//            pulse handshakes. Supports a per-frame bypass mask, a per-stage
//            watchdog, abort, a sticky timeout error and a frame cycle count.
// Ports    : clk          - clock, all state changes on rising edge
//            reset        - asynchronous active-low reset
//            frame_start  - one-cycle request to run a frame
//            stage_enable - bypass mask (bit i = 0 skips stage i)
//            abort        - cancel the frame in progress
//            clear_error  - leave the ERROR state
//            stage_done   - one-cycle done pulses from the layer blocks
//            stage_start  - one-hot one-cycle start pulses to the layer blocks
//            frame_busy   - frame in progress
//            frame_done   - one-cycle pulse when all enabled stages finished
//            cur_stage    - index of the active stage (holds when idle)
//            error        - sticky watchdog timeout flag
//            error_stage  - stage that timed out
//            frame_cycles - cycle count of the last completed frame
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_sequencer #(
  parameter int NUM_STAGES     = 5,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 32,
  localparam int SW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_STAGES-1:0] stage_enable,
  input  logic                  abort,
  input  logic                  clear_error,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [SW-1:0]         cur_stage,
  output logic                  error,
  output logic [SW-1:0]         error_stage,
  output logic [CNT_W-1:0]      frame_cycles
);

  // Watchdog only needs to reach TIMEOUT_CYCLES-1.
  localparam int             WW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0]  c_WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic [NUM_STAGES-1:0] r_mask,   w_mask_nxt;
  logic [WW-1:0]         r_wdog,   w_wdog_nxt;
  logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;

  logic [NUM_STAGES-1:0] w_start_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic [SW-1:0]         w_cur_nxt;
  logic                  w_err_nxt;
  logic [SW-1:0]         w_err_stage_nxt;
  logic [CNT_W-1:0]      w_cycles_nxt;

  logic                  w_first_vld;
  logic [SW-1:0]         w_first_idx;
  logic                  w_next_vld;
  logic [SW-1:0]         w_next_idx;
  logic                  w_honoured;
  logic                  w_timeout;

  // Lowest enabled stage of the incoming mask, and lowest enabled stage of
  // the latched mask above the current one. Scanning downwards leaves the
  // lowest match in the result.
  always_comb begin
    w_first_vld = 1'b0;
    w_first_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_enable[i]) begin
        w_first_vld = 1'b1;
        w_first_idx = SW'(i);
      end
    end
    w_next_vld = 1'b0;
    w_next_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(cur_stage))) begin
        w_next_vld = 1'b1;
        w_next_idx = SW'(i);
      end
    end
  end

  // A done pulse counts only for the active stage and never in its own start
  // cycle, so a block echoing done back during the start pulse is ignored.
  assign w_honoured = (r_state == S_RUN) && (stage_start == '0) &&
                      stage_done[cur_stage];
  assign w_timeout  = (r_wdog == c_WDOG_MAX);

  always_comb begin
    w_state_nxt     = r_state;
    w_mask_nxt      = r_mask;
    w_wdog_nxt      = r_wdog;
    w_cnt_nxt       = r_cnt;
    w_start_nxt     = '0;
    w_busy_nxt      = frame_busy;
    w_done_nxt      = 1'b0;
    w_cur_nxt       = cur_stage;
    w_err_nxt       = error;
    w_err_stage_nxt = error_stage;
    w_cycles_nxt    = frame_cycles;

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_mask_nxt = stage_enable;
          if (w_first_vld) begin
            w_cur_nxt   = w_first_idx;
            w_start_nxt = NUM_STAGES'(1) << w_first_idx;
            w_busy_nxt  = 1'b1;
            w_wdog_nxt  = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            // Empty frame completes immediately with zero cycles.
            w_done_nxt   = 1'b1;
            w_cycles_nxt = '0;
          end
        end
      end

      S_RUN: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // Priority: abort, then done, then timeout.
        if (abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_honoured) begin
          w_wdog_nxt = '0;
          if (w_next_vld) begin
            w_cur_nxt   = w_next_idx;
            w_start_nxt = NUM_STAGES'(1) << w_next_idx;
          end else begin
            // r_cnt is 0 in the first start cycle, so +1 makes the count
            // inclusive of the final done cycle.
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_cycles_nxt = r_cnt + 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err_nxt       = 1'b1;
          w_err_stage_nxt = cur_stage;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_ERROR;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end

      S_ERROR: begin
        if (clear_error) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_wdog       <= '0;
      r_cnt        <= '0;
      stage_start  <= '0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      cur_stage    <= '0;
      error        <= 1'b0;
      error_stage  <= '0;
      frame_cycles <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mask       <= w_mask_nxt;
      r_wdog       <= w_wdog_nxt;
      r_cnt        <= w_cnt_nxt;
      stage_start  <= w_start_nxt;
      frame_busy   <= w_busy_nxt;
      frame_done   <= w_done_nxt;
      cur_stage    <= w_cur_nxt;
      error        <= w_err_nxt;
      error_stage  <= w_err_stage_nxt;
      frame_cycles <= w_cycles_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_sequencer
// Purpose  : Scoreboard bench for cnn_layer_sequencer. Stimulus pushes the
//            expected start/done events (stage or frame_cycles, and the cycle
//            they must appear in) into a queue; a monitor pops and compares
//            whenever the DUT pulses stage_start or frame_done. A layer model
//            answers each start with a done pulse in the 10th cycle of the
//            stage, so every enabled stage accounts for 10 frame cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_sequencer;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic [4:0] stage_enable;
  logic       abort;
  logic       clear_error;
  logic [4:0] stage_done;
  logic [4:0] stage_start;
  logic       frame_busy;
  logic       frame_done;
  logic [2:0] cur_stage;
  logic       error;
  logic [2:0] error_stage;
  logic [31:0] frame_cycles;

  logic [4:0] auto_done;
  logic [4:0] man_done;
  logic       auto_en;
  logic [4:0] hang;
  assign stage_done = auto_done | man_done;

  cnn_layer_sequencer #(
    .NUM_STAGES     (5),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .stage_enable (stage_enable),
    .abort        (abort),
    .clear_error  (clear_error),
    .stage_done   (stage_done),
    .stage_start  (stage_start),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .cur_stage    (cur_stage),
    .error        (error),
    .error_stage  (error_stage),
    .frame_cycles (frame_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int val;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  resp_idx;
  ev_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit is_done, input int val, input int c);
    ev_t x;
    x.is_done = is_done;
    x.val     = val;
    x.cyc     = c;
    q.push_back(x);
  endtask

  task automatic fs(input logic [4:0] mask);
    frame_start  = 1'b1;
    stage_enable = mask;
    goto(cyc + 1);
    frame_start  = 1'b0;
  endtask

  task automatic man_pulse(input int c, input int idx);
    goto(c);
    man_done[idx] = 1'b1;
    goto(c + 1);
    man_done[idx] = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int t;
    t = 0;
    while (q.size() != 0 && t < bound) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  // Frame driven by the layer model; exp_cycles is hand-computed.
  task automatic run_frame(input string name, input logic [4:0] mask, input int exp_cycles);
    int f;
    int n;
    goto(cyc + 1);
    f = cyc;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (mask[k]) begin
        push(1'b0, k, f + 1 + 10 * n);
        n++;
      end
    end
    push(1'b1, exp_cycles, f + 1 + 10 * n);
    fs(mask);
    wait_empty(name, 200);
    check({name, "_cycles"}, frame_cycles, exp_cycles);
    check({name, "_busy"}, frame_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int f;
    reset        = 1'b0;
    frame_start  = 1'b0;
    stage_enable = 5'b0;
    abort        = 1'b0;
    clear_error  = 1'b0;
    auto_done    = 5'b0;
    man_done     = 5'b0;
    auto_en      = 1'b1;
    hang         = 5'b0;

    fork
      // Monitor: every start/done pulse must match the head of the queue.
      forever begin
        @(negedge clk);
        if (reset) begin
          if (stage_start != 5'b0) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_start: got start=%b at cyc %0d, expected none", stage_start, cyc);
            end else begin
              e = q.pop_front();
              if (e.is_done || e.cyc != cyc || stage_start != (5'b00001 << e.val) ||
                  cur_stage != 3'(e.val)) begin
                errors++;
                $display("FAIL start_event: got start=%b cur=%0d cyc=%0d, expected done=%0d stage %0d at cyc %0d",
                         stage_start, cur_stage, cyc, e.is_done, e.val, e.cyc);
              end
            end
          end
          if (frame_done) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_done: got frame_done at cyc %0d, expected none", cyc);
            end else begin
              e = q.pop_front();
              if (!e.is_done || e.cyc != cyc || frame_cycles != e.val || frame_busy) begin
                errors++;
                $display("FAIL done_event: got cycles=%0d busy=%0d cyc=%0d, expected done=%0d cycles %0d at cyc %0d",
                         frame_cycles, frame_busy, cyc, e.is_done, e.val, e.cyc);
              end
            end
          end
        end
      end
      // Layer model: done in the 10th cycle of each started stage.
      forever begin
        @(negedge clk);
        if (reset && auto_en && stage_start != 5'b0) begin
          resp_idx = 0;
          for (int i = 0; i < 5; i++) if (stage_start[i]) resp_idx = i;
          if (!hang[resp_idx]) begin
            repeat (9) @(posedge clk);
            #1 auto_done[resp_idx] = 1'b1;
            @(posedge clk);
            #1 auto_done[resp_idx] = 1'b0;
          end
        end
      end
    join_none

    // Reset state (asynchronous, before any clock edge).
    #1;
    check("rst_start", stage_start, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cur", cur_stage, 0);
    check("rst_err", error, 0);
    check("rst_errstage", error_stage, 0);
    check("rst_cycles", frame_cycles, 0);
    goto(3);
    reset = 1'b1;
    goto(5);

    // Full frame and bypass frames.
    run_frame("full", 5'b11111, 50);
    run_frame("bypass", 5'b10101, 30);
    goto(cyc + 1);
    f = cyc;
    push(1'b1, 0, f + 1);
    fs(5'b00000);
    check("zero_busy", frame_busy, 0);
    wait_empty("zero", 20);
    check("zero_cycles", frame_cycles, 0);

    // Timeout in stage 2 (TIMEOUT_CYCLES = 16).
    goto(cyc + 2);
    hang = 5'b00100;
    f = cyc;
    push(1'b0, 0, f + 1);
    push(1'b0, 1, f + 11);
    push(1'b0, 2, f + 21);
    fs(5'b11111);
    goto(f + 36);
    check("to_err_early", error, 0);
    check("to_busy_early", frame_busy, 1);
    goto(f + 37);
    check("to_err", error, 1);
    check("to_errstage", error_stage, 2);
    check("to_busy", frame_busy, 0);
    check("to_cycles", frame_cycles, 0);
    goto(f + 40);
    fs(5'b11111);
    goto(f + 44);
    check("to_fs_ignored", error, 1);
    check("to_fs_nostart", stage_start, 0);
    clear_error = 1'b1;
    goto(f + 45);
    clear_error = 1'b0;
    check("clr_err", error, 0);
    check("clr_errstage", error_stage, 2);
    wait_empty("timeout", 5);
    hang = 5'b0;
    run_frame("recover", 5'b11111, 50);

    // Spurious done pulses, manually driven.
    goto(cyc + 2);
    auto_en = 1'b0;
    f = cyc;
    push(1'b0, 0, f + 1);
    push(1'b0, 1, f + 4);
    push(1'b0, 2, f + 10);
    push(1'b0, 3, f + 12);
    push(1'b0, 4, f + 14);
    push(1'b1, 15, f + 16);
    fs(5'b11111);
    man_pulse(f + 3, 0);
    man_pulse(f + 4, 1);   // during its own start cycle
    man_pulse(f + 6, 3);   // wrong stage
    man_pulse(f + 9, 1);
    man_pulse(f + 11, 2);
    man_pulse(f + 13, 3);
    man_pulse(f + 15, 4);
    wait_empty("spurious", 20);
    check("spur_cycles", frame_cycles, 15);

    // Abort together with a real done in stage 1.
    goto(cyc + 2);
    f = cyc;
    push(1'b0, 0, f + 1);
    push(1'b0, 1, f + 4);
    fs(5'b11111);
    man_pulse(f + 3, 0);
    goto(f + 5);
    check("abort_busy_pre", frame_busy, 1);
    goto(f + 6);
    man_done[1] = 1'b1;
    abort       = 1'b1;
    goto(f + 7);
    man_done[1] = 1'b0;
    abort       = 1'b0;
    check("abort_busy", frame_busy, 0);
    goto(f + 12);
    check("abort_cycles", frame_cycles, 15);
    check("abort_cur", cur_stage, 1);
    wait_empty("abort", 5);

    // Asynchronous reset in stage 3.
    auto_en = 1'b1;
    goto(cyc + 2);
    f = cyc;
    push(1'b0, 0, f + 1);
    push(1'b0, 1, f + 11);
    push(1'b0, 2, f + 21);
    push(1'b0, 3, f + 31);
    fs(5'b11111);
    goto(f + 35);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", frame_busy, 0);
    check("arst_cur", cur_stage, 0);
    check("arst_start", stage_start, 0);
    check("arst_cycles", frame_cycles, 0);
    check("arst_errstage", error_stage, 0);
    goto(f + 38);
    reset = 1'b1;
    wait_empty("arst", 5);
    goto(f + 46);
    run_frame("after_rst", 5'b11111, 50);

    goto(cyc + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
